// File: rtl/riscv_pkg.sv
// Shared fetch-stage definitions: instruction width, reset vector default,
// fetch FSM state encoding and the prefetch queue entry layout.
package riscv_pkg;

  localparam int ILEN = 32;

  localparam logic [ILEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  typedef struct packed {
    logic [ILEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

  // Branch targets are forced onto a word boundary.
  function automatic logic [ILEN-1:0] align_pc(input logic [ILEN-1:0] pc);
    return pc & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-stage bus bundle: instruction-memory port, redirect input and the
// decode-side valid/ready handshake.
interface instr_fetch_if;
  import riscv_pkg::*;

  logic            imem_req;
  logic [ILEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [ILEN-1:0] imem_rdata;
  logic            redirect_valid;
  logic [ILEN-1:0] redirect_pc;
  logic            if_valid;
  logic            if_ready;
  logic [ILEN-1:0] if_instr;
  logic [ILEN-1:0] if_pc;

  modport master (
    output imem_req, imem_addr, if_valid, if_instr, if_pc,
    input  imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, if_ready
  );

  modport slave (
    input  imem_req, imem_addr, if_valid, if_instr, if_pc,
    output imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, if_ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// Small {pc, instr} prefetch queue with push, pop and a flush that wins over
// both; the head entry is presented combinationally from storage.
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  fetch_entry_t  push_entry,
  input  logic          pop,
  input  logic          flush,
  output fetch_entry_t  head,
  output logic [CW-1:0] count
);

  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  fetch_entry_t  mem_r [DEPTH];
  logic [PW-1:0] rd_ptr_r;
  logic [PW-1:0] wr_ptr_r;
  logic [CW-1:0] count_r;
  logic          push_ok_s;
  logic          pop_ok_s;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? {PW{1'b0}} : p + PTR_ONE;
  endfunction

  // Guard against overflow/underflow so a misbehaving neighbour cannot corrupt pointers.
  always_comb begin
    push_ok_s = push && (count_r < CNT_FULL) && !flush;
    pop_ok_s  = pop && (count_r != {CW{1'b0}}) && !flush;
  end

  // Entry storage; cleared on reset so the head reads zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (push_ok_s) begin
      mem_r[wr_ptr_r] <= push_entry;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_r <= {PW{1'b0}};
      wr_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else if (flush) begin
      rd_ptr_r <= {PW{1'b0}};
      wr_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_ok_s) wr_ptr_r <= ptr_next(wr_ptr_r);
      if (pop_ok_s)  rd_ptr_r <= ptr_next(rd_ptr_r);
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  assign head  = mem_r[rd_ptr_r];
  assign count = count_r;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: single-outstanding IDLE/REQ/WAIT fetch FSM feeding a
// prefetch queue, with branch redirect that flushes and drops in-flight data.
module instr_fetch
  import riscv_pkg::*;
#(
  parameter logic [ILEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int              DEPTH    = 2
) (
  input logic           clk,
  input logic           reset,
  instr_fetch_if.master bus
);

  localparam int              CW       = $clog2(DEPTH + 1);
  localparam logic [CW-1:0]   CNT_FULL = CW'(DEPTH);
  localparam logic [ILEN-1:0] PC_STEP  = 32'd4;

  logic [1:0]      state_r;
  logic [ILEN-1:0] fetch_pc_r;
  logic [ILEN-1:0] req_pc_r;
  logic            stale_r;
  logic            push_s;
  logic            pop_s;
  logic            flush_s;
  logic [ILEN-1:0] redirect_tgt_s;
  fetch_entry_t    push_entry_s;
  fetch_entry_t    head_s;
  logic [CW-1:0]   count_s;

  // Queue control; data returning in the same cycle as a redirect is dropped.
  always_comb begin
    redirect_tgt_s     = align_pc(bus.redirect_pc);
    flush_s            = bus.redirect_valid;
    pop_s              = bus.if_ready && (count_s != {CW{1'b0}});
    push_entry_s.pc    = req_pc_r;
    push_entry_s.instr = bus.imem_rdata;
    if ((state_r == ST_WAIT) && bus.imem_rvalid && !stale_r && !bus.redirect_valid) begin
      push_s = 1'b1;
    end else begin
      push_s = 1'b0;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push_s),
    .push_entry (push_entry_s),
    .pop        (pop_s),
    .flush      (flush_s),
    .head       (head_s),
    .count      (count_s)
  );

  // Fetch FSM. req_pc_r is the address on the bus and is frozen through REQ;
  // fetch_pc_r is the next address to request and absorbs redirects at any time.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      fetch_pc_r <= RESET_PC;
      req_pc_r   <= RESET_PC;
      stale_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.redirect_valid) begin
            fetch_pc_r <= redirect_tgt_s;
            req_pc_r   <= redirect_tgt_s;
            state_r    <= ST_REQ;
          end else if (count_s < CNT_FULL) begin
            req_pc_r <= fetch_pc_r;
            state_r  <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (bus.redirect_valid) begin
            fetch_pc_r <= redirect_tgt_s;
            stale_r    <= 1'b1;
          end else if (bus.imem_gnt && !stale_r) begin
            fetch_pc_r <= req_pc_r + PC_STEP;
          end
          if (bus.imem_gnt) state_r <= ST_WAIT;
        end
        ST_WAIT: begin
          if (bus.imem_rvalid) begin
            state_r <= ST_IDLE;
            stale_r <= 1'b0;
          end else if (bus.redirect_valid) begin
            stale_r <= 1'b1;
          end
          if (bus.redirect_valid) fetch_pc_r <= redirect_tgt_s;
        end
        default: begin
          state_r <= ST_IDLE;
          stale_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.imem_req  = (state_r == ST_REQ);
  assign bus.imem_addr = req_pc_r;
  assign bus.if_valid  = (count_s != {CW{1'b0}});
  assign bus.if_instr  = head_s.instr;
  assign bus.if_pc     = head_s.pc;

endmodule

// File: tb/tb_instr_fetch.sv
// Table-driven bench for instr_fetch: per-cycle stimulus/expectation rows plus a
// delivery scoreboard, and a hand sequence on a second instance for PC wrap.
module tb_instr_fetch;

  typedef struct {
    logic        rst;
    logic        gnt;
    logic        rv;
    logic        redir;
    logic        rdy;
    logic [31:0] rdata;
    logic [31:0] rpc;
    logic        sbp;
    logic [31:0] sb_pc;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
  } vec_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  localparam logic [31:0] Z    = 32'h0000_0000;
  localparam logic [31:0] INSA = 32'h0050_0093;
  localparam logic [31:0] I0   = 32'h0010_0093;
  localparam logic [31:0] I1   = 32'h0020_0113;
  localparam logic [31:0] I2   = 32'h0030_0193;
  localparam logic [31:0] I3   = 32'h0040_0213;
  localparam logic [31:0] I4   = 32'h0050_0293;
  localparam logic [31:0] I5   = 32'h0060_0313;
  localparam logic [31:0] JUNK = 32'hDEAD_BEEF;
  localparam logic [31:0] TOP  = 32'hFFFF_FFFC;

  logic clk;
  logic rst;
  logic rst2;
  int   n_cmp;
  int   n_fail;
  vec_t vq[$];
  exp_t sb[$];

  instr_fetch_if bus_if ();
  instr_fetch_if bus2_if ();

  instr_fetch #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus_if)
  );

  instr_fetch #(.RESET_PC(TOP), .DEPTH(2)) dut2 (
    .clk   (clk),
    .reset (rst2),
    .bus   (bus2_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not reach its summary");
    $fatal(1);
  end

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %h, want %h", name, idx, act, exp);
    end
  endtask

  task automatic add(input logic rs, input logic g, input logic r, input logic [31:0] rd,
                     input logic rdr, input logic [31:0] rp, input logic ry,
                     input logic sp, input logic [31:0] spc,
                     input logic eq, input logic [31:0] ea, input logic ev,
                     input logic [31:0] ep, input logic [31:0] ei);
    vec_t v;
    v.rst = rs; v.gnt = g; v.rv = r; v.rdata = rd; v.redir = rdr; v.rpc = rp; v.rdy = ry;
    v.sbp = sp; v.sb_pc = spc; v.e_req = eq; v.e_addr = ea; v.e_valid = ev;
    v.e_pc = ep; v.e_instr = ei;
    vq.push_back(v);
  endtask

  initial begin
    int   cyc;
    vec_t v;
    exp_t e;
    n_cmp  = 0;
    n_fail = 0;
    rst    = 1'b0;
    rst2   = 1'b0;
    bus_if.imem_gnt  = 1'b0; bus_if.imem_rvalid  = 1'b0; bus_if.imem_rdata  = Z;
    bus_if.redirect_valid = 1'b0; bus_if.redirect_pc = Z; bus_if.if_ready = 1'b0;
    bus2_if.imem_gnt = 1'b0; bus2_if.imem_rvalid = 1'b0; bus2_if.imem_rdata = Z;
    bus2_if.redirect_valid = 1'b0; bus2_if.redirect_pc = Z; bus2_if.if_ready = 1'b0;
    #2;
    rst2 = 1'b1;

    // rst gnt rv rdata redir rpc rdy | sb_push sb_pc | req addr valid pc instr
    add(1'b1,1'b0,1'b0,Z,   1'b0,Z,1'b1, 1'b0,Z, 1'b0,Z,1'b0,Z,Z);
    add(1'b1,1'b0,1'b0,Z,   1'b0,Z,1'b1, 1'b0,Z, 1'b0,Z,1'b0,Z,Z);
    add(1'b0,1'b0,1'b0,Z,   1'b0,Z,1'b1, 1'b0,Z, 1'b0,Z,1'b0,Z,Z);
    add(1'b0,1'b1,1'b0,Z,   1'b0,Z,1'b1, 1'b0,Z, 1'b1,Z,1'b0,Z,Z);
    add(1'b0,1'b0,1'b1,INSA,1'b0,Z,1'b1, 1'b1,Z, 1'b0,Z,1'b0,Z,Z);
    add(1'b0,1'b0,1'b0,Z,   1'b0,Z,1'b1, 1'b0,Z, 1'b0,Z,1'b1,Z,INSA);
    add(1'b0,1'b0,1'b0,Z,   1'b0,Z,1'b1, 1'b0,Z, 1'b1,32'h0000_0004,1'b0,Z,Z);
    add(1'b0,1'b0,1'b0,Z,   1'b0,Z,1'b1, 1'b0,Z, 1'b1,32'h0000_0004,1'b0,Z,Z);
    // reset with a request pending, then continuous gnt/rvalid with decode stalled
    add(1'b1,1'b0,1'b0,Z,   1'b0,Z,1'b1, 1'b0,Z, 1'b0,Z,1'b0,Z,Z);
    add(1'b0,1'b1,1'b1,I0,  1'b0,Z,1'b0, 1'b0,Z, 1'b0,Z,1'b0,Z,Z);
    add(1'b0,1'b1,1'b1,I0,  1'b0,Z,1'b0, 1'b0,Z, 1'b1,Z,1'b0,Z,Z);
    add(1'b0,1'b1,1'b1,I0,  1'b0,Z,1'b0, 1'b1,Z, 1'b0,Z,1'b0,Z,Z);
    add(1'b0,1'b1,1'b1,I0,  1'b0,Z,1'b0, 1'b0,Z, 1'b0,Z,1'b1,Z,I0);
    add(1'b0,1'b1,1'b1,I1,  1'b0,Z,1'b0, 1'b0,Z, 1'b1,32'h0000_0004,1'b1,Z,I0);
    add(1'b0,1'b1,1'b1,I1,  1'b0,Z,1'b0, 1'b1,32'h0000_0004, 1'b0,Z,1'b1,Z,I0);
    for (int i = 0; i < 3; i++) add(1'b0,1'b1,1'b1,I1,1'b0,Z,1'b0, 1'b0,Z, 1'b0,Z,1'b1,Z,I0);
    add(1'b0,1'b0,1'b0,Z,   1'b0,Z,1'b1, 1'b0,Z, 1'b0,Z,1'b1,Z,I0);
    add(1'b0,1'b0,1'b0,Z,   1'b0,Z,1'b1, 1'b0,Z, 1'b0,Z,1'b1,32'h0000_0004,I1);
    add(1'b0,1'b1,1'b0,Z,   1'b0,Z,1'b1, 1'b0,Z, 1'b1,32'h0000_0008,1'b0,Z,Z);
    // redirect to 0x100 while waiting on addr 8
    add(1'b0,1'b0,1'b0,Z,   1'b1,32'h0000_0100,1'b1, 1'b0,Z, 1'b0,Z,1'b0,Z,Z);
    add(1'b0,1'b0,1'b1,JUNK,1'b0,Z,1'b1, 1'b0,Z, 1'b0,Z,1'b0,Z,Z);
    add(1'b0,1'b0,1'b0,Z,   1'b0,Z,1'b1, 1'b0,Z, 1'b0,Z,1'b0,Z,Z);
    add(1'b0,1'b1,1'b0,Z,   1'b0,Z,1'b1, 1'b0,Z, 1'b1,32'h0000_0100,1'b0,Z,Z);
    add(1'b0,1'b0,1'b1,I2,  1'b0,Z,1'b1, 1'b1,32'h0000_0100, 1'b0,Z,1'b0,Z,Z);
    add(1'b0,1'b0,1'b0,Z,   1'b0,Z,1'b0, 1'b0,Z, 1'b0,Z,1'b1,32'h0000_0100,I2);
    // redirect during REQ together with a pop: address held, queue flushed
    add(1'b0,1'b0,1'b0,Z,   1'b1,32'h0000_0300,1'b1, 1'b0,Z, 1'b1,32'h0000_0104,1'b1,32'h0000_0100,I2);
    add(1'b0,1'b1,1'b0,Z,   1'b0,Z,1'b1, 1'b0,Z, 1'b1,32'h0000_0104,1'b0,Z,Z);
    add(1'b0,1'b0,1'b1,JUNK,1'b0,Z,1'b1, 1'b0,Z, 1'b0,Z,1'b0,Z,Z);
    add(1'b0,1'b0,1'b0,Z,   1'b0,Z,1'b1, 1'b0,Z, 1'b0,Z,1'b0,Z,Z);
    add(1'b0,1'b1,1'b0,Z,   1'b0,Z,1'b1, 1'b0,Z, 1'b1,32'h0000_0300,1'b0,Z,Z);
    add(1'b0,1'b0,1'b1,I3,  1'b0,Z,1'b1, 1'b1,32'h0000_0300, 1'b0,Z,1'b0,Z,Z);
    // unaligned redirect in IDLE with a stalled entry queued
    add(1'b0,1'b0,1'b0,Z,   1'b1,32'h0000_0203,1'b0, 1'b0,Z, 1'b0,Z,1'b1,32'h0000_0300,I3);
    add(1'b0,1'b1,1'b0,Z,   1'b0,Z,1'b1, 1'b0,Z, 1'b1,32'h0000_0200,1'b0,Z,Z);
    add(1'b0,1'b0,1'b1,I4,  1'b0,Z,1'b1, 1'b1,32'h0000_0200, 1'b0,Z,1'b0,Z,Z);
    add(1'b0,1'b0,1'b0,Z,   1'b0,Z,1'b1, 1'b0,Z, 1'b0,Z,1'b1,32'h0000_0200,I4);
    add(1'b0,1'b0,1'b0,Z,   1'b0,Z,1'b1, 1'b0,Z, 1'b1,32'h0000_0204,1'b0,Z,Z);
    add(1'b0,1'b1,1'b0,Z,   1'b0,Z,1'b1, 1'b0,Z, 1'b1,32'h0000_0204,1'b0,Z,Z);
    // reset while waiting; late rvalid after release must be ignored
    add(1'b1,1'b0,1'b0,Z,   1'b0,Z,1'b1, 1'b0,Z, 1'b0,Z,1'b0,Z,Z);
    add(1'b0,1'b0,1'b1,JUNK,1'b0,Z,1'b1, 1'b0,Z, 1'b0,Z,1'b0,Z,Z);
    add(1'b0,1'b0,1'b1,JUNK,1'b0,Z,1'b1, 1'b0,Z, 1'b1,Z,1'b0,Z,Z);
    add(1'b0,1'b0,1'b0,Z,   1'b0,Z,1'b1, 1'b0,Z, 1'b1,Z,1'b0,Z,Z);

    for (int k = 0; k < vq.size(); k++) begin
      v = vq[k];
      rst = v.rst;
      bus_if.imem_gnt = v.gnt;
      bus_if.imem_rvalid = v.rv;
      bus_if.imem_rdata = v.rdata;
      bus_if.redirect_valid = v.redir;
      bus_if.redirect_pc = v.rpc;
      bus_if.if_ready = v.rdy;
      #1;
      chk("imem_req", k, {31'd0, bus_if.imem_req}, {31'd0, v.e_req});
      if (v.e_req || v.rst) chk("imem_addr", k, bus_if.imem_addr, v.e_addr);
      chk("if_valid", k, {31'd0, bus_if.if_valid}, {31'd0, v.e_valid});
      if (v.e_valid || v.rst) begin
        chk("if_pc", k, bus_if.if_pc, v.e_pc);
        chk("if_instr", k, bus_if.if_instr, v.e_instr);
      end
      if (v.e_valid && v.rdy) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL sb_pop[%0d]: delivered pc %h, want no delivery", k, bus_if.if_pc);
        end else begin
          e = sb.pop_front();
          chk("sb_pc", k, bus_if.if_pc, e.pc);
          chk("sb_instr", k, bus_if.if_instr, e.instr);
        end
      end
      if (v.redir) sb.delete();
      if (v.sbp) sb.push_back('{pc: v.sb_pc, instr: v.rdata});
      @(posedge clk);
      #1;
    end
    chk("sb_drained", 0, sb.size(), 32'd0);

    // second instance: reset vector at the top of memory, fetch wraps to 0
    chk("dut2_rst_req", 0, {31'd0, bus2_if.imem_req}, 32'd0);
    chk("dut2_rst_addr", 0, bus2_if.imem_addr, TOP);
    rst2 = 1'b0;
    cyc = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
    end while (!bus2_if.imem_req && cyc < 8);
    chk("dut2_req_latency", 0, cyc, 32'd1);
    chk("dut2_addr_first", 0, bus2_if.imem_addr, TOP);
    bus2_if.imem_gnt = 1'b1;
    @(posedge clk);
    #1;
    bus2_if.imem_gnt = 1'b0;
    bus2_if.imem_rvalid = 1'b1;
    bus2_if.imem_rdata = I5;
    chk("dut2_valid_wait", 0, {31'd0, bus2_if.if_valid}, 32'd0);
    @(posedge clk);
    #1;
    bus2_if.imem_rvalid = 1'b0;
    bus2_if.if_ready = 1'b1;
    chk("dut2_valid_next", 0, {31'd0, bus2_if.if_valid}, 32'd1);
    chk("dut2_if_pc", 0, bus2_if.if_pc, TOP);
    chk("dut2_if_instr", 0, bus2_if.if_instr, I5);
    @(posedge clk);
    #1;
    chk("dut2_req_second", 0, {31'd0, bus2_if.imem_req}, 32'd1);
    chk("dut2_addr_wrap", 0, bus2_if.imem_addr, Z);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
